// File: rtl/serial_parity_rx.sv
// Oversampling receiver for start/data(LSB first)/even-parity/stop frames.
// Every decision samples the two-flop synchronised line at mid-bit.
module serial_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic f_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_rx_s;
  logic [CW-1:0]     r_cyc_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W:0]   w_shift_cat;
  logic              r_par_bit;
  logic              w_mid;
  logic              w_last;
  logic              w_stop_smp;

  assign w_rx_s      = r_sync2;
  assign w_mid       = (r_cyc_cnt == C_MID);
  assign w_last      = (r_cyc_cnt == C_LAST);
  assign w_stop_smp  = (r_state == S_STOP) && w_last;
  assign w_shift_cat = {w_rx_s, r_shift};
  assign busy        = (r_state != S_IDLE);

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; START's mid-bit sample fixes the sampling phase for the frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx_s) w_state_nxt = S_START; else w_state_nxt = S_IDLE;
      S_START:  if (w_mid) w_state_nxt = w_rx_s ? S_IDLE : S_DATA; else w_state_nxt = S_START;
      S_DATA:   if (w_last && (r_bit_cnt == B_LAST)) w_state_nxt = S_PARITY; else w_state_nxt = S_DATA;
      S_PARITY: if (w_last) w_state_nxt = S_STOP; else w_state_nxt = S_PARITY;
      S_STOP:   if (w_last) w_state_nxt = w_rx_s ? S_IDLE : S_BREAK; else w_state_nxt = S_STOP;
      S_BREAK:  if (w_rx_s) w_state_nxt = S_IDLE; else w_state_nxt = S_BREAK;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bit-period and bit-index counters, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= {CW{1'b0}};
      r_bit_cnt <= {BW{1'b0}};
    end else if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_BREAK)) begin
      r_cyc_cnt <= {CW{1'b0}};
      r_bit_cnt <= {BW{1'b0}};
    end else begin
      r_cyc_cnt <= w_last ? {CW{1'b0}} : r_cyc_cnt + CW'(1);
      if ((r_state == S_DATA) && w_last) r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  // Deserialiser, parity capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= {DATA_W{1'b0}};
      r_par_bit  <= 1'b0;
      data_out   <= {DATA_W{1'b0}};
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= w_stop_smp;
      if ((r_state == S_DATA) && w_last) r_shift <= w_shift_cat[DATA_W:1];
      if ((r_state == S_PARITY) && w_last) r_par_bit <= w_rx_s;
      if (w_stop_smp) begin
        data_out   <= r_shift;
        parity_err <= f_parity(r_shift) ^ r_par_bit;
        frame_err  <= ~w_rx_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (DATA_W=8, CLKS_PER_BIT=4).
// A monitor logs every data_valid cycle; frames are checked against hand-computed values.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_data[$];
  logic       q_pe[$];
  logic       q_fe[$];

  serial_parity_rx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      q_data.push_back(data_out);
      q_pe.push_back(parity_err);
      q_fe.push_back(frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] d,
                             input logic pe, input logic fe);
    if (q_data.size() > idx) begin
      check({tag, "_data"}, 32'(q_data[idx]), 32'(d));
      check({tag, "_perr"}, 32'(q_pe[idx]), 32'(pe));
      check({tag, "_ferr"}, 32'(q_fe[idx]), 32'(fe));
    end else begin
      check({tag, "_missing"}, 32'(q_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rx_in = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // idle after reset
    tick(100);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(q_data.size()), 32'd0);

    // good frame
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(8);
    check("t2_cnt", 32'(q_data.size()), 32'd1);
    check_frame("t2", 0, 8'hA5, 1'b0, 1'b0);

    // wrong parity
    send_frame(8'h01, 1'b0, 1'b1);
    tick(8);
    check("t3_cnt", 32'(q_data.size()), 32'd2);
    check_frame("t3", 1, 8'h01, 1'b1, 1'b0);

    // bad stop, line held low, then recovery frame
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_in = 1'b0;
    tick(20);
    check("t4_low_cnt", 32'(q_data.size()), 32'd3);
    check("t4_break_busy", 32'(busy), 32'h1);
    rx_in = 1'b1;
    tick(8);
    check("t4_idle_busy", 32'(busy), 32'h0);
    check("t4_idle_cnt", 32'(q_data.size()), 32'd3);
    check_frame("t4a", 2, 8'h3C, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    tick(8);
    check("t4_cnt", 32'(q_data.size()), 32'd4);
    check_frame("t4b", 3, 8'h55, 1'b0, 1'b0);
    check("t4_hold", 32'(data_out), 32'h55);

    // one-cycle glitch
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    tick(2);
    check("t5_start_busy", 32'(busy), 32'h1);
    tick(4);
    check("t5_busy", 32'(busy), 32'h0);
    tick(40);
    check("t5_cnt", 32'(q_data.size()), 32'd4);

    // reset mid-DATA of 0xFF
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick(2);
    check("t6_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_rst", 32'(busy), 32'h0);
    check("t6_data_rst", 32'(data_out), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("t6_abandon_cnt", 32'(q_data.size()), 32'd4);
    send_frame(8'h0F, 1'b0, 1'b1);
    tick(8);
    check("t6_cnt", 32'(q_data.size()), 32'd5);
    check_frame("t6a", 4, 8'h0F, 1'b0, 1'b0);

    // back-to-back frames, no idle gap
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    tick(8);
    check("t6_b2b_cnt", 32'(q_data.size()), 32'd7);
    check_frame("t6b", 5, 8'h12, 1'b0, 1'b0);
    check_frame("t6c", 6, 8'h34, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
